ccd_phase_sequencer: RTL and testbench

Autonomous CCD clock-phase generator for the CCD SoC user area. It derives the photogate (phi_p), two-phase shift register (phi_l1, phi_l2) and reset-gate (phi_r) waveforms from a run enable and a 4-bit frequency select. These are the same control levels the Wishbone CCD control peripheral exposes as `i_enable` and `i_f_select`. The block sits directly downstream of that peripheral, consumes those two levels, and drives the CCD clock pads without per-edge software writes.

---
 rtl/ccd_phase_sequencer_if.sv | 24 ++
 rtl/ccd_phase_sequencer.sv | 159 +++++++++++++++
 tb/tb_ccd_phase_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ccd_phase_sequencer_if.sv
// rtl/ccd_phase_sequencer_if.sv - control levels in, CCD clock pads out
interface ccd_phase_sequencer_if #(
  parameter int PIX_W = 8
);
  logic             i_enable;
  logic [3:0]       i_f_select;
  logic             o_phi_p;
  logic             o_phi_l1;
  logic             o_phi_l2;
  logic             o_phi_r;
  logic             o_busy;
  logic             o_line_done;
  logic [PIX_W-1:0] o_pixel_idx;

  modport master (
    output i_enable, i_f_select,
    input  o_phi_p, o_phi_l1, o_phi_l2, o_phi_r, o_busy, o_line_done, o_pixel_idx
  );

  modport slave (
    input  i_enable, i_f_select,
    output o_phi_p, o_phi_l1, o_phi_l2, o_phi_r, o_busy, o_line_done, o_pixel_idx
  );
endinterface

// File: rtl/ccd_phase_sequencer.sv
// rtl/ccd_phase_sequencer.sv - autonomous CCD photogate/shift/reset phase generator
module ccd_phase_sequencer #(
  parameter int N_PIXELS  = 64,
  parameter int PIX_W     = 8,
  parameter int INT_TICKS = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  ccd_phase_sequencer_if.slave ccd
);
  localparam int CNT_W = $clog2(INT_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INTEGRATE,
    S_TRANSFER,
    S_READOUT
  } state_t;

  state_t           state_q, state_d;
  logic [14:0]      div_q, div_d;
  logic [3:0]       fsel_q, fsel_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [1:0]       sub_q, sub_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             phi_p_q, phi_p_d;
  logic             phi_l1_q, phi_l1_d;
  logic             phi_l2_q, phi_l2_d;
  logic             phi_r_q, phi_r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PIX_W-1:0] idx_q, idx_d;

  logic [15:0] period_oh;
  logic [14:0] tick_max;
  logic        tick;

  // fsel=15 gives period_oh[14:0]=0, so the subtraction wraps to 0x7FFF as intended
  assign period_oh = 16'd1 << fsel_q;
  assign tick_max  = period_oh[14:0] - 15'd1;
  assign tick      = (div_q == tick_max);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    fsel_d  = fsel_q;
    tcnt_d  = tcnt_q;
    sub_d   = sub_q;
    pix_d   = pix_q;
    done_d  = 1'b0;

    if (state_q == S_IDLE) begin
      div_d = 15'd0;
    end else begin
      div_d = tick ? 15'd0 : div_q + 15'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (ccd.i_enable) begin
          fsel_d  = ccd.i_f_select;
          tcnt_d  = '0;
          state_d = S_INTEGRATE;
        end
      end
      S_INTEGRATE: begin
        if (tick) begin
          if (tcnt_q == CNT_W'(INT_TICKS - 1)) begin
            tcnt_d  = '0;
            state_d = S_TRANSFER;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_TRANSFER: begin
        if (tick) begin
          if (tcnt_q == CNT_W'(1)) begin
            tcnt_d  = '0;
            sub_d   = 2'd0;
            pix_d   = '0;
            state_d = S_READOUT;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_READOUT: begin
        if (tick) begin
          sub_d = sub_q + 2'd1;
          if (sub_q == 2'd3) begin
            if (pix_q == PIX_W'(N_PIXELS - 1)) begin
              done_d = 1'b1;
              pix_d  = '0;
              tcnt_d = '0;
              if (ccd.i_enable) begin
                fsel_d  = ccd.i_f_select;
                state_d = S_INTEGRATE;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              pix_d = pix_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state
    phi_p_d  = (state_d == S_INTEGRATE) || (state_d == S_TRANSFER);
    phi_l1_d = (state_d == S_TRANSFER) || ((state_d == S_READOUT) && (sub_d == 2'd1));
    phi_l2_d = (state_d == S_READOUT) && (sub_d == 2'd3);
    phi_r_d  = (state_d == S_READOUT) && (sub_d == 2'd0);
    busy_d   = (state_d != S_IDLE);
    idx_d    = (state_d == S_READOUT) ? pix_d : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      fsel_q   <= '0;
      tcnt_q   <= '0;
      sub_q    <= '0;
      pix_q    <= '0;
      phi_p_q  <= 1'b0;
      phi_l1_q <= 1'b0;
      phi_l2_q <= 1'b0;
      phi_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      fsel_q   <= fsel_d;
      tcnt_q   <= tcnt_d;
      sub_q    <= sub_d;
      pix_q    <= pix_d;
      phi_p_q  <= phi_p_d;
      phi_l1_q <= phi_l1_d;
      phi_l2_q <= phi_l2_d;
      phi_r_q  <= phi_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
    end
  end

  assign ccd.o_phi_p     = phi_p_q;
  assign ccd.o_phi_l1    = phi_l1_q;
  assign ccd.o_phi_l2    = phi_l2_q;
  assign ccd.o_phi_r     = phi_r_q;
  assign ccd.o_busy      = busy_q;
  assign ccd.o_line_done = done_q;
  assign ccd.o_pixel_idx = idx_q;
endmodule

// File: tb/tb_ccd_phase_sequencer.sv
// tb/tb_ccd_phase_sequencer.sv - scoreboard bench for ccd_phase_sequencer
module tb_ccd_phase_sequencer;
  localparam int NPIX = 2;
  localparam int INT  = 4;
  localparam int LT   = INT + 2 + 4 * NPIX;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] exp_q[$];

  ccd_phase_sequencer_if #(.PIX_W(8)) bus ();

  ccd_phase_sequencer #(
    .N_PIXELS (NPIX),
    .PIX_W    (8),
    .INT_TICKS(INT)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .ccd     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // word layout: {idx[7:0], done, busy, r, l2, l1, p}
  function automatic logic [31:0] line_word(int n, int t, bit done);
    int k = n / t;
    int j;
    logic p = 1'b0, l1 = 1'b0, l2 = 1'b0, r = 1'b0;
    logic [7:0] idx = 8'd0;
    if (k < INT) begin
      p = 1'b1;
    end else if (k < INT + 2) begin
      p  = 1'b1;
      l1 = 1'b1;
    end else begin
      j   = k - INT - 2;
      idx = 8'(j / 4);
      case (j % 4)
        0: r = 1'b1;
        1: l1 = 1'b1;
        3: l2 = 1'b1;
        default: ;
      endcase
    end
    return {18'd0, idx, done, 1'b1, r, l2, l1, p};
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    logic [31:0] act;
    #1;
    if (exp_q.size() > 0) begin
      w   = exp_q.pop_front();
      act = {18'd0, bus.o_pixel_idx, bus.o_line_done, bus.o_busy,
             bus.o_phi_r, bus.o_phi_l2, bus.o_phi_l1, bus.o_phi_p};
      chk($sformatf("wave@%0t", $time), act, w);
      chk("overlap", 32'(bus.o_phi_l1 & bus.o_phi_l2), 32'd0);
    end
  end

  task automatic drain();
    for (int i = 0; i < 5000 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic push_line(input int f, input bit first_done);
    int t = 1 << f;
    for (int n = 0; n < LT * t; n++) exp_q.push_back(line_word(n, t, first_done && n == 0));
  endtask

  // enable goes low `hold` negedges after the start; alt_f is applied mid-line for single lines
  task automatic run_lines(input int f, input int alt_f, input int nlines, input int hold);
    bus.i_f_select = 4'(f);
    bus.i_enable   = 1'b1;
    for (int l = 0; l < nlines; l++) push_line(f, l > 0);
    exp_q.push_back(32'h0000_0020);
    exp_q.push_back(32'h0);
    @(negedge clk);
    if (nlines == 1) bus.i_f_select = 4'(alt_f);
    repeat (hold - 1) @(negedge clk);
    bus.i_enable = 1'b0;
    drain();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.i_enable   = 1'b0;
    bus.i_f_select = 4'd0;
    repeat (3) @(negedge clk);
    exp_q.push_back(32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    drain();

    run_lines(0, 0, 1, 1);
    run_lines(3, 0, 1, 1);
    run_lines(1, 1, 3, 2 * LT * 2 + 3);
    run_lines(2, 2, 1, (INT + 3) * 4);

    bus.i_f_select = 4'd0;
    bus.i_enable   = 1'b1;
    for (int n = 0; n <= INT; n++) exp_q.push_back(line_word(n, 1, 1'b0));
    repeat (3) exp_q.push_back(32'h0);
    @(negedge clk);
    bus.i_enable = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drain();

    run_lines(0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
